// File: rtl/ula_controlador_if.sv
// Command and result channels between a command source and ula_controlador.
interface ula_controlador_if #(
    parameter int LARGURA = 8
);
    logic                   Cmd_Valid;
    logic                   Cmd_Ready;
    logic [3:0]             Cmd_Op;
    logic [LARGURA-1:0]     Cmd_A;
    logic [LARGURA-1:0]     Cmd_B;
    logic                   Cmd_Encadeia;
    logic                   Res_Valid;
    logic                   Res_Ready;
    logic [2*LARGURA-1:0]   Res_Dado;
    logic                   Res_Erro;

    // Command source / result consumer side
    modport master (
        output Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B, Cmd_Encadeia, Res_Ready,
        input  Cmd_Ready, Res_Valid, Res_Dado, Res_Erro
    );

    // Controller side
    modport slave (
        input  Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B, Cmd_Encadeia, Res_Ready,
        output Cmd_Ready, Res_Valid, Res_Dado, Res_Erro
    );
endinterface

// File: rtl/ula_controlador.sv
// Command-side initiator for the 8-bit ULA: one operation per handshake,
// registered operands to the ULA, result delivered on a valid/ready port
// with illegal-opcode and division-by-zero flagging.
module ula_controlador #(
    parameter int LARGURA      = 8,
    parameter int LARGURA_CONT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    ula_controlador_if.slave        bus,
    output logic [LARGURA-1:0]      Ula_A,
    output logic [LARGURA-1:0]      Ula_B,
    output logic [3:0]              Ula_Sel_Op,
    input  logic [2*LARGURA-1:0]    Ula_Resultado,
    output logic [LARGURA_CONT-1:0] Contador_Ops
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t              estado;
    estado_t              estado_prox;
    logic                 aceita;
    logic                 conclui;
    logic                 entrega;
    logic                 erro_pend;
    logic                 op_ilegal;
    logic                 div_zero;
    logic [2*LARGURA-1:0] ultimo;

    // Opcode legality and division-by-zero detection on the incoming command
    always_comb begin
        op_ilegal = (bus.Cmd_Op == 4'b0101) || (bus.Cmd_Op >= 4'b1101);
        div_zero  = ((bus.Cmd_Op == 4'b0011) || (bus.Cmd_Op == 4'b0100))
                    && (bus.Cmd_B == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic, command-ready and datapath strobes
    always_comb begin
        estado_prox   = estado;
        bus.Cmd_Ready = 1'b0;
        aceita        = 1'b0;
        conclui       = 1'b0;
        entrega       = 1'b0;
        case (estado)
            OCIOSO: begin
                bus.Cmd_Ready = 1'b1;
                if (bus.Cmd_Valid) begin
                    aceita      = 1'b1;
                    estado_prox = EXECUTA;
                end
            end
            EXECUTA: begin
                conclui     = 1'b1;
                estado_prox = ENTREGA;
            end
            ENTREGA: begin
                if (bus.Res_Ready) begin
                    entrega     = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Operand/result registers, last-result store and delivered-op counter
    always_ff @(posedge clk) begin
        if (rst) begin
            Ula_A         <= '0;
            Ula_B         <= '0;
            Ula_Sel_Op    <= '0;
            erro_pend     <= 1'b0;
            bus.Res_Valid <= 1'b0;
            bus.Res_Dado  <= '0;
            bus.Res_Erro  <= 1'b0;
            ultimo        <= '0;
            Contador_Ops  <= '0;
        end else begin
            if (aceita) begin
                Ula_A      <= bus.Cmd_Encadeia ? ultimo[LARGURA-1:0] : bus.Cmd_A;
                Ula_B      <= bus.Cmd_B;
                Ula_Sel_Op <= bus.Cmd_Op;
                erro_pend  <= op_ilegal || div_zero;
            end
            if (conclui) begin
                bus.Res_Dado  <= erro_pend ? '0 : Ula_Resultado;
                bus.Res_Erro  <= erro_pend;
                bus.Res_Valid <= 1'b1;
            end
            if (entrega) begin
                bus.Res_Valid <= 1'b0;
                Contador_Ops  <= Contador_Ops + LARGURA_CONT'(1);
                if (!bus.Res_Erro) begin
                    ultimo <= bus.Res_Dado;
                end
            end
        end
    end

endmodule
